// File: rtl/action_exec_pkg.sv
// Shared constants for the action-execution stage: widths, action field slices and opcodes.
// Statistics counters in action_exec are built only when ACTION_EXEC_STATS_EN is defined.
package action_exec_pkg;

   localparam int unsigned DATA_W_DEF     = 512;
   localparam int unsigned ACT_W_DEF      = 16;
   localparam int unsigned STATE_W_DEF    = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF      = 32;

   localparam int unsigned OP_HI  = 15;
   localparam int unsigned OP_LO  = 12;
   localparam int unsigned SEL_HI = 11;
   localparam int unsigned SEL_LO = 8;
   localparam int unsigned IMM_HI = 7;
   localparam int unsigned IMM_LO = 0;

   // Egress-port byte occupies the top byte of the vector.
   localparam int unsigned PORT_LO = 504;

   localparam logic [3:0] OP_NOP       = 4'd0;
   localparam logic [3:0] OP_DROP      = 4'd1;
   localparam logic [3:0] OP_SET_BYTE  = 4'd2;
   localparam logic [3:0] OP_SET_STATE = 4'd3;
   localparam logic [3:0] OP_ADD_BYTE  = 4'd4;
   localparam logic [3:0] OP_SET_PORT  = 4'd5;

   function automatic logic [6:0] byte_lsb(input logic [3:0] sel);
      return {sel, 3'b000};
   endfunction

endpackage

// File: rtl/action_exec_pkt_fifo.sv
// Synchronous show-ahead FIFO with simultaneous push/pop; a push while full succeeds only
// when a pop frees a slot in the same cycle. Head data reads as zero while empty.
module pkt_fifo #(
   parameter int unsigned W     = 512,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_vld,
   output logic         o_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_push_ok;
   logic          w_pop_ok;

   assign o_vld     = (r_count != '0);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign w_pop_ok  = i_pop && o_vld;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_data    = o_vld ? r_mem[r_rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/action_exec.sv
// Applies the decoded 16-bit action to each packet vector and buffers survivors in pkt_fifo.
// Define ACTION_EXEC_STATS_EN to build the forwarded/dropped/overflow counters.
module action_exec
   import action_exec_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ACT_W      = ACT_W_DEF,
   parameter int unsigned STATE_W    = STATE_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pkt_vld_in,
   input  logic [DATA_W-1:0] pkt_data_in,
   input  logic [ACT_W-1:0]  action_in,
   input  logic [STATE_W-1:0] state_in,
   output logic              pkt_vld_out,
   output logic [DATA_W-1:0] pkt_data_out,
   input  logic              out_rdy,
   output logic              fifo_full,
   output logic [CNT_W-1:0]  fwd_cnt,
   output logic [CNT_W-1:0]  drop_cnt,
   output logic [CNT_W-1:0]  ovf_cnt
);

   localparam int unsigned IDX_W = $clog2(DATA_W);

   logic               r_vld;
   logic [DATA_W-1:0]  r_data;
   logic [ACT_W-1:0]   r_act;
   logic [STATE_W-1:0] r_state;

   logic [3:0]         w_op;
   logic [3:0]         w_sel;
   logic [7:0]         w_imm;
   logic [IDX_W-1:0]   w_lsb;
   logic [DATA_W-1:0]  w_res;
   logic               w_push;
   logic               w_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_vld <= 1'b0;
      else       r_vld <= pkt_vld_in;
   end

   // Payload registers only matter while r_vld is set, so they carry no reset.
   always_ff @(posedge clk) begin
      if (pkt_vld_in) begin
         r_data  <= pkt_data_in;
         r_act   <= action_in;
         r_state <= state_in;
      end
   end

   assign w_op  = r_act[OP_HI:OP_LO];
   assign w_sel = r_act[SEL_HI:SEL_LO];
   assign w_imm = r_act[IMM_HI:IMM_LO];
   assign w_lsb = IDX_W'(byte_lsb(w_sel));

   always_comb begin
      w_res = r_data;
      case (w_op)
         OP_SET_BYTE:  w_res[w_lsb +: 8] = w_imm;
         OP_SET_STATE: w_res[w_lsb +: 8] = 8'(r_state);
         OP_ADD_BYTE:  w_res[w_lsb +: 8] = r_data[w_lsb +: 8] + w_imm;
         OP_SET_PORT:  w_res[PORT_LO +: 8] = w_imm;
         default:      w_res = r_data;
      endcase
   end

   assign w_push = r_vld && (w_op != OP_DROP);
   assign w_pop  = pkt_vld_out && out_rdy;

   pkt_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_push (w_push),
      .i_data (w_res),
      .i_pop  (w_pop),
      .o_data (pkt_data_out),
      .o_vld  (pkt_vld_out),
      .o_full (fifo_full)
   );

`ifdef ACTION_EXEC_STATS_EN
   logic             w_drop;
   logic             w_ovf;
   logic [CNT_W-1:0] r_fwd_cnt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [CNT_W-1:0] r_ovf_cnt;

   assign w_drop = r_vld && (w_op == OP_DROP);
   assign w_ovf  = w_push && fifo_full && !out_rdy;

   // Saturating counters: hold at all-ones rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fwd_cnt  <= '0;
         r_drop_cnt <= '0;
         r_ovf_cnt  <= '0;
      end else begin
         if (w_pop  && (r_fwd_cnt  != '1)) r_fwd_cnt  <= r_fwd_cnt  + CNT_W'(1);
         if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
         if (w_ovf  && (r_ovf_cnt  != '1)) r_ovf_cnt  <= r_ovf_cnt  + CNT_W'(1);
      end
   end

   assign fwd_cnt  = r_fwd_cnt;
   assign drop_cnt = r_drop_cnt;
   assign ovf_cnt  = r_ovf_cnt;
`else
   assign fwd_cnt  = '0;
   assign drop_cnt = '0;
   assign ovf_cnt  = '0;
`endif

endmodule

// File: tb/tb_action_exec.sv
// Scoreboard bench for action_exec: stimulus queues expected packets, a negedge monitor
// pops and compares on every handshake. Counter expectations follow ACTION_EXEC_STATS_EN.
module tb_action_exec;

   logic         clk = 1'b0;
   logic         reset;
   logic         pkt_vld_in;
   logic [511:0] pkt_data_in;
   logic [15:0]  action_in;
   logic [7:0]   state_in;
   logic         pkt_vld_out;
   logic [511:0] pkt_data_out;
   logic         out_rdy;
   logic         fifo_full;
   logic [31:0]  fwd_cnt;
   logic [31:0]  drop_cnt;
   logic [31:0]  ovf_cnt;

   int total = 0;
   int bad   = 0;
   logic [511:0] exp_q[$];

   action_exec dut (
      .clk          (clk),
      .reset        (reset),
      .pkt_vld_in   (pkt_vld_in),
      .pkt_data_in  (pkt_data_in),
      .action_in    (action_in),
      .state_in     (state_in),
      .pkt_vld_out  (pkt_vld_out),
      .pkt_data_out (pkt_data_out),
      .out_rdy      (out_rdy),
      .fifo_full    (fifo_full),
      .fwd_cnt      (fwd_cnt),
      .drop_cnt     (drop_cnt),
      .ovf_cnt      (ovf_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] c(input logic [31:0] v);
`ifdef ACTION_EXEC_STATS_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head must match the oldest expected packet.
   always @(negedge clk) begin
      if (!reset && pkt_vld_out && out_rdy) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %0h expected no packet", pkt_data_out);
         end else begin
            chk("out_data", pkt_data_out, exp_q.pop_front());
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [511:0] d, input logic [15:0] a, input logic [7:0] s,
                        input bit fwd, input logic [511:0] e);
      pkt_vld_in  = 1'b1;
      pkt_data_in = d;
      action_in   = a;
      state_in    = s;
      if (fwd) exp_q.push_back(e);
      cyc(1);
   endtask

   task automatic idle();
      pkt_vld_in = 1'b0;
      action_in  = 16'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [511:0] d;
      reset = 1'b0; pkt_vld_in = 1'b0; pkt_data_in = '0; action_in = '0; state_in = '0;
      out_rdy = 1'b1;
      #1 reset = 1'b1;
      #1;
      chk("rst_vld",  512'(pkt_vld_out), 512'd0);
      chk("rst_data", pkt_data_out, 512'd0);
      chk("rst_full", 512'(fifo_full), 512'd0);
      chk("rst_cnts", 512'({fwd_cnt, drop_cnt, ovf_cnt}), 512'd0);
      cyc(2);
      reset = 1'b0;
      cyc(1);

      // Single SET_BYTE packet: latency and one-cycle output pulse.
      drive(512'h4322, 16'h21AB, 8'h00, 1'b1, 512'hAB22);
      idle();
      chk("lat_early", 512'(pkt_vld_out), 512'd0);
      cyc(1);
      chk("lat_on", 512'(pkt_vld_out), 512'd1);
      cyc(1);
      chk("lat_off", 512'(pkt_vld_out), 512'd0);
      chk("fwd_1", 512'(fwd_cnt), 512'(c(32'd1)));

      // Back-to-back opcode mix with out_rdy high.
      drive(512'h4322, 16'h40FF, 8'h00, 1'b1, 512'h4321);
      drive(512'h4322, 16'h3000, 8'h5A, 1'b1, 512'h435A);
      drive(512'h4322, 16'h2177, 8'h00, 1'b1, 512'h7722);
      drive(512'h4322, 16'h4101, 8'h00, 1'b1, 512'h4422);
      drive(512'h4322, 16'h50C3, 8'h00, 1'b1, 512'h4322 | (512'hC3 << 504));
      drive(512'h4322, 16'h2F99, 8'h00, 1'b1, 512'h4322 | (512'h99 << 120));
      drive(512'h4322, 16'h9000, 8'h00, 1'b1, 512'h4322);
      idle();
      cyc(3);
      chk("fwd_8", 512'(fwd_cnt), 512'(c(32'd8)));
      chk("q_empty_mix", 512'(exp_q.size()), 512'd0);

      // DROP: no output, drop_cnt bumps at the stage-2 edge.
      do_reset();
      drive(512'h4322, 16'h1000, 8'h00, 1'b0, 512'h0);
      idle();
      cyc(1);
      chk("drop_n1", 512'(drop_cnt), 512'(c(32'd1)));
      cyc(2);
      chk("drop_vld", 512'(pkt_vld_out), 512'd0);
      chk("drop_fwd", 512'(fwd_cnt), 512'd0);

      // Overflow: six packets into a stalled 4-deep FIFO.
      do_reset();
      out_rdy = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d = 512'(i + 1) << 8;
         drive(d, 16'h0000, 8'h00, (i < 4), d);
      end
      idle();
      cyc(2);
      chk("ovf_full", 512'(fifo_full), 512'd1);
      chk("ovf_cnt2", 512'(ovf_cnt), 512'(c(32'd2)));
      chk("hold_1", pkt_data_out, 512'h100);
      cyc(3);
      chk("hold_2", pkt_data_out, 512'h100);
      out_rdy = 1'b1;
      cyc(6);
      chk("drain_full", 512'(fifo_full), 512'd0);
      chk("drain_fwd", 512'(fwd_cnt), 512'(c(32'd4)));
      chk("q_empty_ovf", 512'(exp_q.size()), 512'd0);

      // Full FIFO, push coinciding with a pop is accepted.
      do_reset();
      out_rdy = 1'b0;
      drive(512'hA0, 16'h0000, 8'h00, 1'b1, 512'hA0);
      drive(512'hB0, 16'h0000, 8'h00, 1'b1, 512'hB0);
      drive(512'hC0, 16'h0000, 8'h00, 1'b1, 512'hC0);
      drive(512'hD0, 16'h0000, 8'h00, 1'b1, 512'hD0);
      drive(512'hE0, 16'h0000, 8'h00, 1'b1, 512'hE0);
      idle();
      chk("pre_full", 512'(fifo_full), 512'd1);
      out_rdy = 1'b1;
      cyc(1);
      out_rdy = 1'b0;
      chk("pp_full", 512'(fifo_full), 512'd1);
      chk("pp_ovf", 512'(ovf_cnt), 512'd0);
      chk("pp_fwd", 512'(fwd_cnt), 512'(c(32'd1)));
      out_rdy = 1'b1;
      cyc(1);
      out_rdy = 1'b0;
      chk("three_vld", 512'(pkt_vld_out), 512'd1);
      chk("three_head", pkt_data_out, 512'hC0);

      // Asynchronous reset with three entries buffered.
      reset = 1'b1;
      exp_q.delete();
      #1;
      chk("arst_vld",  512'(pkt_vld_out), 512'd0);
      chk("arst_full", 512'(fifo_full), 512'd0);
      chk("arst_data", pkt_data_out, 512'd0);
      chk("arst_cnts", 512'({fwd_cnt, drop_cnt, ovf_cnt}), 512'd0);
      cyc(1);
      reset = 1'b0;
      out_rdy = 1'b1;
      cyc(1);

      drive(512'h55, 16'h2E11, 8'h00, 1'b1, 512'h55 | (512'h11 << 112));
      idle();
      cyc(3);
      chk("q_empty_end", 512'(exp_q.size()), 512'd0);
      chk("fwd_end", 512'(fwd_cnt), 512'(c(32'd1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
